// File: rtl/line_buffer_13rows_pkg.sv
// Shared constants and helpers for the 13-row line buffer.
package line_buffer_13rows_pkg;

    localparam int PIX_W    = 8;
    localparam int WIN_ROWS = 13;
    localparam int LINES    = WIN_ROWS - 1;

    typedef logic [PIX_W-1:0] pix_t;

    // Counter width for a modulo-n counter; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/line_buffer_13rows_if.sv
// Pixel stream in, 13 column taps plus valid/frame-end flags out.
interface line_buffer_13rows_if;
    import line_buffer_13rows_pkg::*;

    logic done_i;
    pix_t data_i;
    pix_t S1_o;
    pix_t S2_o;
    pix_t S3_o;
    pix_t S4_o;
    pix_t S5_o;
    pix_t S6_o;
    pix_t S7_o;
    pix_t S8_o;
    pix_t S9_o;
    pix_t S10_o;
    pix_t S11_o;
    pix_t S12_o;
    pix_t S13_o;
    logic done_o;
    logic progress_done_o;

    modport master (
        output done_i, data_i,
        input  S1_o, S2_o, S3_o, S4_o, S5_o, S6_o, S7_o,
        input  S8_o, S9_o, S10_o, S11_o, S12_o, S13_o,
        input  done_o, progress_done_o
    );

    modport slave (
        input  done_i, data_i,
        output S1_o, S2_o, S3_o, S4_o, S5_o, S6_o, S7_o,
        output S8_o, S9_o, S10_o, S11_o, S12_o, S13_o,
        output done_o, progress_done_o
    );

endinterface

// File: rtl/line_buffer_13rows_line_fifo.sv
// One row of pixel history: combinational read of the old word, write on the
// same edge, so chained instances shift a column down by one row per accept.
module line_buffer_13rows_line_fifo
    import line_buffer_13rows_pkg::*;
#(
    parameter int COLS = 15,
    parameter int AW   = cnt_width(COLS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  pix_t          din,
    output pix_t          dout
);

    pix_t mem [COLS];

    assign dout = mem[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= din;
        end
    end

endmodule

// File: rtl/line_buffer_13rows.sv
// Raster pixel stream to 13 column-aligned row taps (current row and 12 back),
// with frame position tracking to qualify the taps.
module line_buffer_13rows
    import line_buffer_13rows_pkg::*;
#(
    parameter int COLS = 15,
    parameter int ROWS = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    line_buffer_13rows_if.slave  bus
);

    localparam int CW = cnt_width(COLS);
    localparam int RW = cnt_width(ROWS);

    localparam logic [CW-1:0] COL_LAST     = CW'(COLS - 1);
    localparam logic [RW-1:0] ROW_LAST     = RW'(ROWS - 1);
    localparam logic [RW-1:0] ROW_FULL_WIN = RW'(WIN_ROWS - 1);

    logic [CW-1:0] col_cnt;
    logic [CW-1:0] col_nxt;
    logic [RW-1:0] row_cnt;
    logic [RW-1:0] row_nxt;
    logic          col_wrap;
    logic          frame_end;

    pix_t line_rd [LINES];
    pix_t line_wr [LINES];

    pix_t taps_p1 [WIN_ROWS];
    logic vld_p1;
    logic prog_p1;

    always_comb begin
        col_wrap  = (col_cnt == COL_LAST);
        frame_end = col_wrap && (row_cnt == ROW_LAST);
        col_nxt   = col_wrap ? '0 : col_cnt + CW'(1);
        row_nxt   = row_cnt;
        if (frame_end) begin
            row_nxt = '0;
        end else if (col_wrap) begin
            row_nxt = row_cnt + RW'(1);
        end
    end

    // Line 1 takes the incoming pixel; each deeper line takes the word its
    // predecessor is about to overwrite.
    assign line_wr[0] = bus.data_i;

    for (genvar j = 1; j < LINES; j++) begin : g_cascade
        assign line_wr[j] = line_rd[j-1];
    end

    for (genvar j = 0; j < LINES; j++) begin : g_line
        line_buffer_13rows_line_fifo #(
            .COLS (COLS),
            .AW   (CW)
        ) u_line (
            .clk  (clk),
            .we   (bus.done_i),
            .addr (col_cnt),
            .din  (line_wr[j]),
            .dout (line_rd[j])
        );
    end

    // ---- stage p1: registered taps and flags, aligned one cycle after accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_cnt <= '0;
            row_cnt <= '0;
            vld_p1  <= 1'b0;
            prog_p1 <= 1'b0;
            for (int k = 0; k < WIN_ROWS; k++) begin
                taps_p1[k] <= '0;
            end
        end else begin
            vld_p1  <= bus.done_i && (row_cnt >= ROW_FULL_WIN);
            prog_p1 <= bus.done_i && frame_end;
            if (bus.done_i) begin
                col_cnt <= col_nxt;
                row_cnt <= row_nxt;
                taps_p1[WIN_ROWS-1] <= bus.data_i;
                // Deepest line lands on the oldest tap.
                for (int k = 0; k < LINES; k++) begin
                    taps_p1[k] <= line_rd[LINES-1-k];
                end
            end
        end
    end

    assign bus.S1_o  = taps_p1[0];
    assign bus.S2_o  = taps_p1[1];
    assign bus.S3_o  = taps_p1[2];
    assign bus.S4_o  = taps_p1[3];
    assign bus.S5_o  = taps_p1[4];
    assign bus.S6_o  = taps_p1[5];
    assign bus.S7_o  = taps_p1[6];
    assign bus.S8_o  = taps_p1[7];
    assign bus.S9_o  = taps_p1[8];
    assign bus.S10_o = taps_p1[9];
    assign bus.S11_o = taps_p1[10];
    assign bus.S12_o = taps_p1[11];
    assign bus.S13_o = taps_p1[12];

    assign bus.done_o          = vld_p1;
    assign bus.progress_done_o = prog_p1;

endmodule

// File: tb/tb_line_buffer_13rows.sv
// Directed bench for line_buffer_13rows with COLS=ROWS=15; pixel value is the
// linear index within the frame, mod 256.
module tb_line_buffer_13rows;
  import line_buffer_13rows_pkg::*;

  localparam int COLS  = 15;
  localparam int ROWS  = 15;
  localparam int FRAME = COLS * ROWS;

  logic clk = 1'b0;
  logic rst = 1'b0;

  line_buffer_13rows_if bus();

  line_buffer_13rows #(.COLS(COLS), .ROWS(ROWS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_tests  = 0;
  int n_fail   = 0;
  int hi_cnt   = 0;
  int prog_cnt = 0;

  function automatic logic [7:0] tap(input int k);
    case (k)
      1:  return bus.S1_o;
      2:  return bus.S2_o;
      3:  return bus.S3_o;
      4:  return bus.S4_o;
      5:  return bus.S5_o;
      6:  return bus.S6_o;
      7:  return bus.S7_o;
      8:  return bus.S8_o;
      9:  return bus.S9_o;
      10: return bus.S10_o;
      11: return bus.S11_o;
      12: return bus.S12_o;
      default: return bus.S13_o;
    endcase
  endfunction

  // Present one pixel for one clock, then sample outputs just after the edge.
  task automatic accept(input int idx);
    bus.done_i = 1'b1;
    bus.data_i = 8'(idx);
    @(posedge clk); #1;
    bus.done_i = 1'b0;
    if (bus.done_o) hi_cnt++;
    if (bus.progress_done_o) prog_cnt++;
  endtask

  task automatic idle();
    bus.done_i = 1'b0;
    @(posedge clk); #1;
    if (bus.done_o) hi_cnt++;
    if (bus.progress_done_o) prog_cnt++;
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if (bus.done_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_done: got %b want 0", bus.done_o);
    end
    n_tests++;
    if (bus.progress_done_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_prog: got %b want 0", bus.progress_done_o);
    end
    for (int k = 1; k <= 13; k++) begin
      n_tests++;
      if (tap(k) !== 8'd0) begin
        n_fail++; $display("FAIL reset_S%0d: got %0d want 0", k, tap(k));
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_fill();
    int early_hi;
    hi_cnt = 0; prog_cnt = 0; early_hi = 0;
    for (int i = 0; i < 180; i++) begin
      accept(i);
      if (bus.done_o) early_hi++;
    end
    n_tests++;
    if (early_hi !== 0) begin
      n_fail++; $display("FAIL fill_done_low: done_o high %0d cycles, want 0", early_hi);
    end
    accept(180);
    n_tests++;
    if (bus.done_o !== 1'b1) begin
      n_fail++; $display("FAIL fill_done_180: got %b want 1", bus.done_o);
    end
    n_tests++;
    if (bus.progress_done_o !== 1'b0) begin
      n_fail++; $display("FAIL fill_prog_180: got %b want 0", bus.progress_done_o);
    end
    // Hand values: S13=180 S12=165 S7=90 S1=0; every tap is one row (15) apart.
    for (int k = 1; k <= 13; k++) begin
      n_tests++;
      if (tap(k) !== 8'(180 - 15 * (13 - k))) begin
        n_fail++; $display("FAIL fill_S%0d: got %0d want %0d", k, tap(k), 180 - 15 * (13 - k));
      end
    end
  endtask

  task automatic test_frame_end();
    for (int i = 181; i < 224; i++) accept(i);
    n_tests++;
    if (prog_cnt !== 0) begin
      n_fail++; $display("FAIL early_prog: got %0d pulses want 0", prog_cnt);
    end
    accept(224);
    n_tests++;
    if (bus.progress_done_o !== 1'b1 || bus.done_o !== 1'b1) begin
      n_fail++; $display("FAIL end_flags: prog=%b done=%b want 1 1", bus.progress_done_o, bus.done_o);
    end
    n_tests++;
    if (bus.S13_o !== 8'd224 || bus.S1_o !== 8'd44) begin
      n_fail++; $display("FAIL end_taps: S13=%0d S1=%0d want 224 44", bus.S13_o, bus.S1_o);
    end
    idle();
    n_tests++;
    if (bus.progress_done_o !== 1'b0 || bus.done_o !== 1'b0) begin
      n_fail++; $display("FAIL end_after: prog=%b done=%b want 0 0", bus.progress_done_o, bus.done_o);
    end
    n_tests++;
    if (hi_cnt !== 45 || prog_cnt !== 1) begin
      n_fail++; $display("FAIL frame_counts: done_hi=%0d prog=%0d want 45 1", hi_cnt, prog_cnt);
    end
  endtask

  task automatic test_stall();
    hi_cnt = 0; prog_cnt = 0;
    for (int i = 0; i <= 190; i++) accept(i);
    n_tests++;
    if (bus.done_o !== 1'b1 || bus.S13_o !== 8'd190 || bus.S1_o !== 8'd10) begin
      n_fail++; $display("FAIL stall_pre: done=%b S13=%0d S1=%0d want 1 190 10", bus.done_o, bus.S13_o, bus.S1_o);
    end
    for (int c = 0; c < 5; c++) begin
      idle();
      n_tests++;
      if (bus.done_o !== 1'b0 || bus.S13_o !== 8'd190 || bus.S1_o !== 8'd10) begin
        n_fail++; $display("FAIL stall_hold%0d: done=%b S13=%0d S1=%0d want 0 190 10", c, bus.done_o, bus.S13_o, bus.S1_o);
      end
    end
    accept(191);
    n_tests++;
    if (bus.done_o !== 1'b1 || bus.S13_o !== 8'd191 || bus.S1_o !== 8'd11) begin
      n_fail++; $display("FAIL stall_resume: done=%b S13=%0d S1=%0d want 1 191 11", bus.done_o, bus.S13_o, bus.S1_o);
    end
    for (int i = 192; i < FRAME; i++) accept(i);
    n_tests++;
    if (hi_cnt !== 45 || prog_cnt !== 1) begin
      n_fail++; $display("FAIL stall_counts: done_hi=%0d prog=%0d want 45 1", hi_cnt, prog_cnt);
    end
  endtask

  task automatic test_reset_midframe();
    for (int i = 0; i <= 100; i++) accept(i);
    rst = 1'b1;
    #1;
    n_tests++;
    if (bus.done_o !== 1'b0 || bus.progress_done_o !== 1'b0) begin
      n_fail++; $display("FAIL midrst_flags: done=%b prog=%b want 0 0", bus.done_o, bus.progress_done_o);
    end
    for (int k = 1; k <= 13; k++) begin
      n_tests++;
      if (tap(k) !== 8'd0) begin
        n_fail++; $display("FAIL midrst_S%0d: got %0d want 0", k, tap(k));
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    test_fill();
    for (int i = 181; i < FRAME; i++) accept(i);
    n_tests++;
    if (prog_cnt !== 1) begin
      n_fail++; $display("FAIL midrst_prog: got %0d pulses want 1", prog_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int f2_hi;
    hi_cnt = 0; prog_cnt = 0; f2_hi = 0;
    for (int i = 0; i < 405; i++) begin
      accept(i);
      if (i >= FRAME && bus.done_o) f2_hi++;
    end
    n_tests++;
    if (f2_hi !== 0) begin
      n_fail++; $display("FAIL b2b_f2_low: done_o high %0d cycles, want 0", f2_hi);
    end
    accept(405);
    n_tests++;
    if (bus.done_o !== 1'b1 || bus.S13_o !== 8'd149 || bus.S1_o !== 8'd225) begin
      n_fail++; $display("FAIL b2b_first: done=%b S13=%0d S1=%0d want 1 149 225", bus.done_o, bus.S13_o, bus.S1_o);
    end
    for (int i = 406; i < 2 * FRAME; i++) accept(i);
    n_tests++;
    if (hi_cnt !== 90 || prog_cnt !== 2) begin
      n_fail++; $display("FAIL b2b_counts: done_hi=%0d prog=%0d want 90 2", hi_cnt, prog_cnt);
    end
  endtask

  task automatic test_random();
    int idx, cyc, pulses, errs;
    bit go;
    idx = 0; cyc = 0; pulses = 0; errs = 0;
    while (idx < FRAME && cyc < 3000) begin
      go = 1'($urandom_range(0, 1));
      bus.done_i = go;
      bus.data_i = 8'(idx);
      @(posedge clk); #1;
      bus.done_i = 1'b0;
      cyc++;
      if (bus.progress_done_o) pulses++;
      if (go) begin
        n_tests++;
        if (bus.done_o !== (idx >= 180)) begin
          n_fail++; errs++;
          $display("FAIL rnd_done idx=%0d: got %b want %b", idx, bus.done_o, idx >= 180);
        end
        n_tests++;
        if (bus.progress_done_o !== (idx == FRAME - 1)) begin
          n_fail++; errs++;
          $display("FAIL rnd_prog idx=%0d: got %b want %b", idx, bus.progress_done_o, idx == FRAME - 1);
        end
        if (bus.done_o) begin
          for (int k = 1; k <= 13; k++) begin
            n_tests++;
            if (tap(k) !== 8'(idx - 15 * (13 - k))) begin
              n_fail++; errs++;
              $display("FAIL rnd_S%0d idx=%0d: got %0d want %0d", k, idx, tap(k), 8'(idx - 15 * (13 - k)));
            end
          end
        end
        idx++;
      end else begin
        n_tests++;
        if (bus.done_o !== 1'b0 || bus.progress_done_o !== 1'b0) begin
          n_fail++; errs++;
          $display("FAIL rnd_idle idx=%0d: done=%b prog=%b want 0 0", idx, bus.done_o, bus.progress_done_o);
        end
        if (idx > 0) begin
          n_tests++;
          if (bus.S13_o !== 8'(idx - 1)) begin
            n_fail++; errs++;
            $display("FAIL rnd_hold idx=%0d: S13=%0d want %0d", idx, bus.S13_o, 8'(idx - 1));
          end
        end
      end
    end
    n_tests++;
    if (idx != FRAME) begin
      n_fail++; $display("FAIL rnd_timeout: accepted %0d want %0d", idx, FRAME);
    end
    n_tests++;
    if (pulses !== 1) begin
      n_fail++; $display("FAIL rnd_pulses: got %0d want 1", pulses);
    end
  endtask

  initial begin
    bus.done_i = 1'b0;
    bus.data_i = '0;
    test_reset();
    test_fill();
    test_frame_end();
    test_stall();
    test_reset_midframe();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
